// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: operand width, FSM
// state encoding and the 4-bit carry-lookahead helper used by the adder.
package shift_add_multiplier_pkg;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Carries {c4,c3,c2,c1} of a 4-bit group, each written directly from the
   // bit generates/propagates and the group carry-in (no internal ripple).
   function automatic logic [3:0] cla4(input logic [3:0] g,
                                       input logic [3:0] p,
                                       input logic       c0);
      logic [3:0] c;
      c[0] = g[0] | (p[0] & c0);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

endpackage

// File: rtl/A2_Q1_carry_look_ahead_adder.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
// The group carry of the low nibble feeds the high nibble.
module A2_Q1_carry_look_ahead_adder
   import shift_add_multiplier_pkg::*;
(
   output logic             C_out,
   output logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in
);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   carry;
   logic [3:0]       lo_c;
   logic [3:0]       hi_c;

   // Generate/propagate, lookahead carries per nibble, then the sum bits.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a value on
      // every path; otherwise synthesis infers a latch to hold the old one.
      gen        = A & B;
      prop       = A ^ B;
      carry      = '0;
      carry[0]   = C_in;
      lo_c       = cla4(gen[3:0], prop[3:0], carry[0]);
      carry[4:1] = lo_c;
      hi_c       = cla4(gen[7:4], prop[7:4], carry[4]);
      carry[8:5] = hi_c;
      S          = prop ^ carry[WIDTH-1:0];
      C_out      = carry[WIDTH];
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per clock over
// WIDTH cycles, using a single carry-lookahead adder. The product is
// registered and published with a one-cycle done pulse.
module shift_add_multiplier #(
   parameter int WIDTH = shift_add_multiplier_pkg::WIDTH  // only 8 supported
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] P
);

   import shift_add_multiplier_pkg::*;

   state_e             state_q;
   logic [WIDTH-1:0]   m_q;      // captured multiplicand
   logic [WIDTH-1:0]   q_q;      // multiplier, shifting right; fills with low product bits
   logic [WIDTH-1:0]   h_q;      // upper half accumulator
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] p_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               carry_out;
   logic [WIDTH-1:0]   h_d;
   logic [WIDTH-1:0]   q_d;
   logic [CNT_W-1:0]   cnt_d;

   A2_Q1_carry_look_ahead_adder u_adder (
      .C_out (carry_out),
      .S     (sum),
      .A     (h_q),
      .B     (addend),
      .C_in  (1'b0)
   );

   // One iteration: add M when the multiplier LSB is set, then shift the
   // 17-bit {carry,sum,Q} right; the carry lands in H bit 7 so nothing is lost.
   always_comb begin
      addend = q_q[0] ? m_q : '0;
      h_d    = {carry_out, sum[WIDTH-1:1]};
      q_d    = {sum[0], q_q[WIDTH-1:1]};
      cnt_d  = cnt_q + CNT_W'(1);
   end

   // Control FSM and datapath registers; rst has priority over everything.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         q_q     <= '0;
         h_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  m_q     <= A;
                  q_q     <= B;
                  h_q     <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               h_q   <= h_d;
               q_q   <= q_d;
               cnt_q <= cnt_d;
               // The eighth step publishes its own shifted result directly.
               if (cnt_d == CNT_W'(WIDTH)) begin
                  p_q     <= {h_d, q_d};
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign P    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: hand-computed products, latency,
// back-to-back throughput, start-ignore and reset-abort behaviour.
module tb_shift_add_multiplier;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        busy;
   logic        done;
   logic [15:0] P;

   int errors = 0;
   int checks = 0;

   shift_add_multiplier #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One multiply with start pulsed for a single cycle. Edges are numbered
   // from the start-sampling edge (edge 1); done must appear after edge 9.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p);
      int done_edge;
      int busy_cnt;
      int overlap;
      done_edge = 0;
      busy_cnt  = 0;
      overlap   = 0;
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 20; n++) begin
         #1;
         if (n == 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (busy && done) overlap++;
         if (done) begin
            done_edge = n;
            break;
         end
         @(posedge clk);
      end
      check({tag, "_latency"}, done_edge, 9);
      check({tag, "_busy_cycles"}, busy_cnt, 8);
      check({tag, "_busy_done_overlap"}, overlap, 0);
      check({tag, "_P"}, P, exp_p);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_P_hold"}, P, exp_p);
   endtask

   initial begin
      int last_done;
      int n_done;
      int done_edge;
      int extra_done;
      int extra_busy;

      rst   = 1'b1;
      start = 1'b1;
      A     = 8'd5;
      B     = 8'd5;

      // Reset state, with start asserted alongside rst.
      repeat (2) @(posedge clk);
      #1;
      check("reset_P", P, 16'h0000);
      check("reset_done", done, 0);
      check("reset_busy", busy, 0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("idle_no_start_busy", busy, 0);

      // Directed products.
      run_op("m13x11", 8'd13, 8'd11, 16'h008F);
      run_op("mFFxFF", 8'hFF, 8'hFF, 16'hFE01);
      run_op("m00xA5", 8'h00, 8'hA5, 16'h0000);
      run_op("m80x02", 8'h80, 8'h02, 16'h0100);

      // start held high: captured values 3*5 each time, period 10 edges,
      // with A/B disturbed mid-RUN and restored once done is seen.
      @(negedge clk);
      A = 8'd3;
      B = 8'd5;
      start = 1'b1;
      last_done = -1;
      n_done = 0;
      for (int e = 1; e <= 40 && n_done < 3; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            check("cont_P", P, 16'd15);
            check("cont_period", e - last_done, 10);
            n_done++;
            last_done = e;
            A = 8'd3;
            B = 8'd5;
            if (n_done == 3) start = 1'b0;
         end else if (e - last_done == 4) begin
            A = 8'd200;
            B = 8'd100;
         end
      end
      check("cont_done_count", n_done, 3);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("cont_idle_after", busy, 0);

      // start pulsed during RUN and during DONE must be ignored.
      @(negedge clk);
      A = 8'h21;
      B = 8'h06;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b1;
      A = 8'hFF;
      B = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      done_edge = 0;
      for (int n = 3; n <= 20; n++) begin
         if (done) begin
            done_edge = n;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("ign_latency", done_edge, 9);
      check("ign_P", P, 16'h00C6);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      extra_done = 0;
      extra_busy = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (done) extra_done++;
         if (busy) extra_busy++;
      end
      check("ign_extra_done", extra_done, 0);
      check("ign_extra_busy", extra_busy, 0);
      check("ign_P_hold", P, 16'h00C6);

      // Reset after the 4th RUN cycle aborts the multiply and clears P.
      @(negedge clk);
      A = 8'h55;
      B = 8'h03;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_P", P, 16'h0000);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      rst = 1'b0;
      extra_done = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) extra_done++;
      end
      check("abort_no_done", extra_done, 0);
      run_op("m07x09", 8'd7, 8'd9, 16'h003F);

      // rst and start on the same edge: start discarded.
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      A = 8'd2;
      B = 8'd2;
      @(posedge clk);
      #1;
      check("rst_start_busy", busy, 0);
      check("rst_start_P", P, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("rst_start_no_capture", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width; only 8 is supported, matching the 8-bit adder sub-module.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, 8, multiplicand (unsigned); sampled with start.
REQ-006 The block SHALL have port B, input, 8, multiplier (unsigned); sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high while iterating (RUN).
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse when P is updated.
REQ-009 The block SHALL have port P, output, 16, registered unsigned product A*B.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL capture A into multiplicand reg M, B into shift reg Q, clear the 8-bit accumulator H and 4-bit counter, and go to RUN.
REQ-012 Each RUN cycle, the block SHALL compute {c,s} = H + (Q[0] ? M : 0) through the adder with C_in=0, then load {H,Q} <= {c,s,Q} >> 1 and increment the counter.
REQ-013 After exactly 8 RUN cycles, the block SHALL go to DONE and load P <= {H,Q} on that same edge.
REQ-014 The block SHALL hold done=1 for exactly the single DONE cycle and then return to IDLE.
REQ-015 Latency SHALL be 9 clock edges from the start-sampling edge to done asserted; with start held high, throughput is one product per 10 cycles.
REQ-016 busy SHALL be 1 in RUN only; busy and done SHALL never both be 1.
REQ-017 The block SHALL ignore start in RUN and DONE; A and B changes after capture SHALL not affect the result.
REQ-018 The block SHALL hold P stable from the DONE edge until the next DONE edge, and SHALL not change it during IDLE or RUN.
REQ-019 The carry-out c of each add SHALL be retained as H bit 7 after the shift, so that 0xFF*0xFF yields 0xFE01 with no overflow.
REQ-020 The counter SHALL not wrap: the RUN->DONE transition occurs when the count reaches 8, and the counter is cleared on capture.

Reset
REQ-021 On rst=1 at a clock edge, the block SHALL enter IDLE and clear P, done, busy, M, Q, H and the counter to 0, regardless of current state.
REQ-022 If rst and start are high on the same edge, rst SHALL take priority and start SHALL be discarded.
REQ-023 A reset asserted mid-RUN SHALL abort the operation with no done pulse, and P SHALL read 0.

Structure
REQ-024 A shared package SHALL hold WIDTH=8 and the state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10.
REQ-025 The block SHALL instantiate exactly one sub-module, A2_Q1_carry_look_ahead_adder (ports C_out,S,A,B,C_in), for the add; it SHALL contain no other adder.

Verification
REQ-026 The bench SHALL drive A=13, B=11 with start pulsed, and check P=0x008F with done exactly 9 edges later and busy high for 8 cycles.
REQ-027 The bench SHALL drive A=0xFF, B=0xFF, and check P=0xFE01, which exercises the carry-out path.
REQ-028 The bench SHALL drive A=0x00, B=0xA5, then A=0x80, B=0x02, and check P=0x0000 and then P=0x0100.
REQ-029 The bench SHALL hold start=1 continuously with A=3, B=5, then change A/B mid-RUN, and check that every done gives P=15 (captured values) with a done period of 10 cycles.
REQ-030 The bench SHALL assert rst for one cycle after the 4th RUN cycle, and check P=0, done=0, busy=0, and that the next start gives a correct product.
REQ-031 The bench SHALL pulse start during RUN and during DONE, and check that both are ignored with no extra done and P unchanged.
